// File: rtl/mem_access_ctrl_if.sv
// Bus between the control unit and mem_access_ctrl: request, memory strobes and completion status.
// Handshake: start is sampled only while busy=0; the request is accepted on that edge and done pulses once when it finishes.
interface mem_access_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [2:0]  sh_sel;
    logic        load_en;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  dbg_state;

    modport master (
        output start, op, addr,
        input  mem_addr, mem_wr, sh_sel, load_en, busy, done, err, dbg_state
    );

    modport slave (
        input  start, op, addr,
        output mem_addr, mem_wr, sh_sel, load_en, busy, done, err, dbg_state
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences sb/sh/sw/lb/lh/lw accesses against a memory with MEM_LAT-cycle read latency.
// Optional MEM_ALIGN_CHECK_EN: misaligned lw/sw/lh/sh finish immediately with err and no memory access.
module mem_access_ctrl #(
    parameter int MEM_LAT = 2
) (
    input logic              clk,
    input logic              reset_n,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_LOAD  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [2:0] OP_SB = 3'b000;
    localparam logic [2:0] OP_SW = 3'b001;
    localparam logic [2:0] OP_SH = 3'b010;
    localparam logic [2:0] OP_LB = 3'b011;
    localparam logic [2:0] OP_LW = 3'b100;
    localparam logic [2:0] OP_LH = 3'b101;
    localparam logic [2:0] LP_CNT_INIT = 3'(MEM_LAT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_cnt;
    logic [2:0]  r_op_q;
    logic [29:0] r_word_addr;
    logic        r_err;
    logic        w_misaligned;
    logic        w_reject;
    logic        w_load_q;
    logic        w_mem_wr;
    logic        w_load_en;
    logic [2:0]  w_sh_sel;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = ((bus.op == OP_LW || bus.op == OP_SW) && bus.addr[1:0] != 2'b00) ||
                          ((bus.op == OP_LH || bus.op == OP_SH) && bus.addr[0]);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_reject = (bus.op > OP_LH) || w_misaligned;
    assign w_load_q = (r_op_q == OP_LB) || (r_op_q == OP_LW) || (r_op_q == OP_LH);

    always_comb begin
        w_state_next = r_state;
        w_mem_wr     = 1'b0;
        w_load_en    = 1'b0;
        w_sh_sel     = 3'b111;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_reject)
                        w_state_next = S_DONE;
                    else if (bus.op == OP_SW)
                        w_state_next = S_WRITE;
                    else
                        w_state_next = S_READ;
                end
            end
            S_READ: begin
                if (r_cnt == 3'd0) begin
                    if (w_load_q)
                        w_state_next = S_LOAD;
                    else
                        w_state_next = S_MERGE;
                end
            end
            S_MERGE: begin
                w_sh_sel     = r_op_q;
                w_state_next = S_WRITE;
            end
            S_WRITE: begin
                w_sh_sel     = r_op_q;
                w_mem_wr     = 1'b1;
                w_state_next = S_DONE;
            end
            S_LOAD: begin
                w_sh_sel     = r_op_q;
                w_load_en    = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // The wait counter is reloaded on every acceptance; only READ consumes it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_op_q      <= 3'd0;
            r_word_addr <= 30'd0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && bus.start) begin
                r_op_q      <= bus.op;
                r_word_addr <= bus.addr[31:2];
                r_err       <= w_reject;
                r_cnt       <= LP_CNT_INIT;
            end else if (r_state == S_READ && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    assign bus.mem_addr  = {r_word_addr, 2'b00};
    assign bus.mem_wr    = w_mem_wr;
    assign bus.load_en   = w_load_en;
    assign bus.sh_sel    = w_sh_sel;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.err       = (r_state == S_DONE) && r_err;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus random ops, scored on each done pulse.
module tb_mem_access_ctrl;
    localparam int ML = 2;
    localparam int EW = 9;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.MEM_LAT(ML)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int unsigned t0 = 0;
    int unsigned wr_cnt = 0;
    int unsigned ld_cnt = 0;
    int unsigned wr_total = 0;
    int unsigned done_total = 0;
    int unsigned last_done_cyc = 0;
    int unsigned w0 = 0;
    int unsigned d0 = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected record: {err, latency[3:0], mem_wr pulses[1:0], load_en pulses[1:0]}
    function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [31:0] addr);
        logic bad;
        logic mis;
        bad = (op >= 3'd6);
        mis = ((op == 3'd4 || op == 3'd1) && addr[1:0] != 2'b00) ||
              ((op == 3'd5 || op == 3'd2) && addr[0]);
        if (ALIGN_EN && mis) bad = 1'b1;
        if (bad) return {1'b1, 4'd1, 2'd0, 2'd0};
        case (op)
            3'd1:       return {1'b0, 4'd2, 2'd1, 2'd0};
            3'd0, 3'd2: return {1'b0, 4'(ML + 3), 2'd1, 2'd0};
            default:    return {1'b0, 4'(ML + 2), 2'd0, 2'd1};
        endcase
    endfunction

    always @(negedge clk) begin
        if (bus.mem_wr) begin
            wr_cnt++;
            wr_total++;
        end
        if (bus.load_en) ld_cnt++;
        if (bus.done) begin
            done_total++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("err", {31'd0, bus.err}, {31'd0, mon_e[8]});
                check_val("latency", cyc - t0, {28'd0, mon_e[7:4]});
                check_val("wr_pulses", wr_cnt, {30'd0, mon_e[3:2]});
                check_val("load_pulses", ld_cnt, {30'd0, mon_e[1:0]});
            end
            wr_cnt = 0;
            ld_cnt = 0;
            last_done_cyc = cyc;
        end
    end

    // Caller sits at a negedge with the DUT idle; returns at the negedge of cycle 1.
    task automatic drive_op(input logic [2:0] op, input logic [31:0] addr);
        bus.start = 1'b1;
        bus.op    = op;
        bus.addr  = addr;
        exp_q.push_back(model(op, addr));
        t0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'($urandom_range(0, 7));
        bus.addr  = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("idle_timeout", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        bus.start = 1'b1;
        bus.op    = 3'd1;
        bus.addr  = 32'h40;
        repeat (3) @(negedge clk);
        check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_val("rst_done", {31'd0, bus.done}, 32'd0);
        check_val("rst_err", {31'd0, bus.err}, 32'd0);
        check_val("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        check_val("rst_load_en", {31'd0, bus.load_en}, 32'd0);
        check_val("rst_sh_sel", {29'd0, bus.sh_sel}, 32'd7);
        check_val("rst_mem_addr", bus.mem_addr, 32'd0);
        bus.start = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);
        check_val("idle_after_rst", {31'd0, bus.busy}, 32'd0);

        // sw 0x40
        drive_op(3'd1, 32'h40);
        check_val("sw_mem_wr", {31'd0, bus.mem_wr}, 32'd1);
        check_val("sw_sh_sel", {29'd0, bus.sh_sel}, 32'd1);
        check_val("sw_mem_addr", bus.mem_addr, 32'h40);
        @(negedge clk);
        check_val("sw_done", {31'd0, bus.done}, 32'd1);
        check_val("sw_wr_low_in_done", {31'd0, bus.mem_wr}, 32'd0);
        wait_idle();

        // lb 0x13
        drive_op(3'd3, 32'h13);
        for (int i = 0; i < ML; i++) begin
            check_val("lb_read_addr", bus.mem_addr, 32'h10);
            check_val("lb_read_wr", {31'd0, bus.mem_wr}, 32'd0);
            check_val("lb_read_sh_sel", {29'd0, bus.sh_sel}, 32'd7);
            check_val("lb_read_load_en", {31'd0, bus.load_en}, 32'd0);
            @(negedge clk);
        end
        check_val("lb_load_en", {31'd0, bus.load_en}, 32'd1);
        check_val("lb_sh_sel", {29'd0, bus.sh_sel}, 32'd3);
        wait_idle();

        // sh 0x22
        drive_op(3'd2, 32'h22);
        repeat (ML) @(negedge clk);
        check_val("sh_merge_wr", {31'd0, bus.mem_wr}, 32'd0);
        check_val("sh_merge_sh_sel", {29'd0, bus.sh_sel}, 32'd2);
        @(negedge clk);
        check_val("sh_write_wr", {31'd0, bus.mem_wr}, 32'd1);
        check_val("sh_write_sh_sel", {29'd0, bus.sh_sel}, 32'd2);
        check_val("sh_write_addr", bus.mem_addr, 32'h20);
        wait_idle();

        // invalid ops and a misaligned lw
        drive_op(3'd6, 32'h0);
        check_val("inv_done", {31'd0, bus.done}, 32'd1);
        check_val("inv_err", {31'd0, bus.err}, 32'd1);
        check_val("inv_wr", {31'd0, bus.mem_wr}, 32'd0);
        wait_idle();
        drive_op(3'd7, 32'h8);
        wait_idle();
        drive_op(3'd4, 32'h41);
        wait_idle();

        // start pulsed during READ of lw must be dropped
        drive_op(3'd4, 32'h80);
        bus.start = 1'b1;
        bus.op    = 3'd1;
        bus.addr  = 32'h100;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check_val("no_queued_start", {31'd0, bus.busy}, 32'd0);

        // reset while in WRITE of sb
        drive_op(3'd0, 32'h30);
        repeat (ML + 1) @(negedge clk);
        check_val("sb_write_before_rst", {31'd0, bus.mem_wr}, 32'd1);
        reset_n = 1'b0;
        d0 = done_total;
        @(negedge clk);
        check_val("abort_wr", {31'd0, bus.mem_wr}, 32'd0);
        check_val("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_val("abort_sh_sel", {29'd0, bus.sh_sel}, 32'd7);
        check_val("abort_addr", bus.mem_addr, 32'd0);
        exp_q.delete();
        wr_cnt = 0;
        ld_cnt = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("abort_no_done", done_total, d0);

        // back-to-back sw then lw
        w0 = wr_total;
        drive_op(3'd1, 32'h50);
        wait_idle();
        drive_op(3'd4, 32'h54);
        check_val("b2b_accept_gap", t0 - last_done_cyc, 32'd1);
        check_val("b2b_busy", {31'd0, bus.busy}, 32'd1);
        wait_idle();
        check_val("b2b_wr_total", wr_total - w0, 32'd1);

        // random traffic
        repeat (20) begin
            drive_op(3'($urandom_range(0, 7)), $urandom);
            wait_idle();
        end
        repeat (2) @(negedge clk);
        check_val("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, memory read latency in cycles; legal range 1..7.
REQ-002 SHALL have ports: clk  in  1  system clock, rising edge active.
REQ-003 SHALL have ports: reset_n  in  1  synchronous active-low reset.
REQ-004 SHALL have ports: start  in  1  request from control unit, sampled only in IDLE.
REQ-005 SHALL have ports: op  in  3  access code: 000 sb, 001 sw, 010 sh, 011 lb, 100 lw, 101 lh; 110/111 invalid.
REQ-006 SHALL have ports: addr  in  32  byte address of access.
REQ-007 SHALL have ports: mem_addr  out  32  word address to memory, {addr_q[31:2],2'b00}.
REQ-008 SHALL have ports: mem_wr  out  1  memory write enable.
REQ-009 SHALL have ports: sh_sel  out  3  select to size-handler merge/extract mux.
REQ-010 SHALL have ports: load_en  out  1  write enable for the load data register.
REQ-011 SHALL have ports: busy  out  1  high in every state except IDLE.
REQ-012 SHALL have ports: done  out  1  one-cycle completion pulse.
REQ-013 SHALL have ports: err  out  1  error flag, valid only while done=1.

Function
REQ-014 SHALL implement states IDLE, READ, MERGE, WRITE, LOAD, DONE.
REQ-015 In IDLE with start=1 SHALL latch op and addr into op_q/addr_q and leave IDLE on the same edge.
REQ-016 IDLE transition: sw -> WRITE; sb, sh, lb, lw, lh -> READ with wait counter loaded to MEM_LAT-1; invalid op -> DONE with err=1.
REQ-017 READ SHALL hold mem_wr=0 and decrement the counter each cycle, exiting after exactly MEM_LAT cycles.
REQ-018 READ exit: loads -> LOAD; sb/sh -> MERGE.
REQ-019 MERGE SHALL last 1 cycle: sh_sel=op_q, mem_wr=0, then -> WRITE.
REQ-020 WRITE SHALL last 1 cycle: sh_sel=op_q, mem_wr=1, then -> DONE.
REQ-021 LOAD SHALL last 1 cycle: sh_sel=op_q, load_en=1, then -> DONE.
REQ-022 DONE SHALL last 1 cycle: done=1, err as determined, then -> IDLE.
REQ-023 Outside MERGE/WRITE/LOAD, sh_sel SHALL be 3'b111.
REQ-024 Latency from the accepting edge to done: sw 2 cycles; loads MEM_LAT+2; sb/sh MEM_LAT+3; error 1.
REQ-025 start while busy=1 SHALL be ignored, with no queuing.
REQ-026 addr/op changes after acceptance SHALL have no effect until the next acceptance.
REQ-027 A new start SHALL be accepted in the IDLE cycle directly following DONE, giving back-to-back operation.
REQ-028 mem_wr SHALL be high for exactly one cycle per store and never for loads or errors.

Reset
REQ-029 reset_n=0 at a rising edge SHALL force IDLE, counter=0, op_q=0, addr_q=0.
REQ-030 Output reset values: mem_wr=0, load_en=0, done=0, err=0, busy=0, sh_sel=3'b111, mem_addr=0.
REQ-031 Reset mid-operation, including in WRITE, SHALL abort with no done pulse.
REQ-032 After a mid-operation reset, mem_wr SHALL be low from the cycle after the reset edge.

Configuration
REQ-033 Macro MEM_ALIGN_CHECK_EN defined: in IDLE, lw/sw with addr[1:0]!=0 or lh/sh with addr[0]!=0 SHALL go -> DONE with err=1 and no memory access.
REQ-034 Macro MEM_ALIGN_CHECK_EN undefined: no alignment check; err SHALL be raised only for invalid op.

Verification (MEM_LAT=2)
REQ-035 Reset, then sw addr=0x40 -> WRITE at cycle 1 with mem_wr=1, sh_sel=001, mem_addr=0x40; done at cycle 2, err=0.
REQ-036 lb addr=0x13 -> READ for 2 cycles with mem_addr=0x10, then LOAD with load_en=1, sh_sel=011, then done at cycle 4.
REQ-037 sh addr=0x22 -> READ x2, MERGE (mem_wr=0), WRITE (mem_wr=1, sh_sel=010); done at cycle 5.
REQ-038 op=110 -> done with err=1 at cycle 1, no mem_wr.
REQ-038 note: with MEM_ALIGN_CHECK_EN, lw addr=0x41 -> done with err=1 at cycle 1, no mem_wr.
REQ-039 start pulsed during READ of lw -> ignored; reset_n=0 during WRITE -> next cycle IDLE, mem_wr=0, no done.
REQ-040 Back-to-back sw then lw -> second start accepted in the IDLE cycle after done; mem_wr pulses exactly once in total.
